// File: rtl/edge_detector_param_if.sv
// Shared pixel-SRAM port used by edge_detector_param: the detector drives address/data_write/wren
// and receives data_read from the arbiter.
interface edge_detector_param_if #(
  parameter int unsigned ADDR_W = 18
) ();
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_read;
  logic [31:0]       data_write;
  logic              wren;

  modport master (
    output address,
    output data_write,
    output wren,
    input  data_read
  );

  modport slave (
    input  address,
    input  data_write,
    input  wren,
    output data_read
  );
endinterface

// File: rtl/edge_detector_param.sv
// Parametrised windowed-average edge detector walking a source frame in pixel SRAM.
// Define EDGE_DETECTION_AVG_DEBUG_EN to write per-channel window averages instead of the edge flag.
module edge_detector_param #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned WINDOW     = 16,
  parameter int unsigned STEP       = 2,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SRC_BASE   = 76800,
  parameter int unsigned DST_BASE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause,
  input  logic                  enable_edge_detection,
  input  logic [7:0]            edge_detection_threshold_red,
  input  logic [7:0]            edge_detection_threshold_green,
  input  logic [7:0]            edge_detection_threshold_blue,
  edge_detector_param_if.master sram,
  output logic                  edge_detection_done,
  output logic [ADDR_W-1:0]     edge_count
);

  localparam int unsigned M          = WINDOW / 2;
  localparam int unsigned WS         = WINDOW / STEP;
  localparam int unsigned N          = WS * WS;
  localparam int unsigned LOG_N      = $clog2(N);
  localparam int unsigned SUM_W      = 8 + LOG_N;
  localparam int unsigned ISSUE_LAST = N + 2;
  localparam int unsigned CNT_W      = $clog2(N + 3 + RD_LATENCY);
  localparam int unsigned XW         = $clog2(IMG_WIDTH);
  localparam int unsigned YW         = $clog2(IMG_HEIGHT);
  localparam int unsigned X_LAST     = IMG_WIDTH - M - 1;
  localparam int unsigned Y_LAST     = IMG_HEIGHT - M - 1;

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDecide, StWrite, StDone} state_e;

  state_e                           state_q, state_d;
  logic [XW-1:0]                    x_q, x_d;
  logic [YW-1:0]                    y_q, y_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [RD_LATENCY-1:0]            vld_q, vld_d;
  logic [RD_LATENCY-1:0][CNT_W-1:0] idx_q, idx_d;
  logic [2:0][7:0]                  cen_q, cen_d, rgt_q, rgt_d, blw_q, blw_d;
  logic [2:0][SUM_W-1:0]            sum_q, sum_d;
  logic                             flag_q, flag_d;
  logic [31:0]                      result_q, result_d;
  logic [ADDR_W-1:0]                edge_count_q, edge_count_d;

  logic [2:0][7:0] thr, pix, avg;
  logic [2:0][8:0] avt;
  logic [2:0]      hit;
  logic [CNT_W-1:0] cap_idx;
  logic            unused_ch;
  int unsigned     k, sx, sy;

  assign unused_ch = ^sram.data_read[23:16];

  // Per-channel window average and edge decision; only consumed in StDecide.
  always_comb begin
    thr = {edge_detection_threshold_blue, edge_detection_threshold_green,
           edge_detection_threshold_red};
    pix = {sram.data_read[31:24], sram.data_read[15:8], sram.data_read[7:0]};
    for (int c = 0; c < 3; c++) begin
      avg[c] = 8'(sum_q[c] >> LOG_N);
      avt[c] = {1'b0, avg[c]} + {1'b0, thr[c]};
      hit[c] = (({1'b0, cen_q[c]} >  avt[c]) &&
                (({1'b0, rgt_q[c]} < avt[c]) || ({1'b0, blw_q[c]} < avt[c]))) ||
               (({1'b0, cen_q[c]} <= avt[c]) &&
                (({1'b0, rgt_q[c]} > avt[c]) || ({1'b0, blw_q[c]} > avt[c])));
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    cen_d        = cen_q;
    rgt_d        = rgt_q;
    blw_d        = blw_q;
    sum_d        = sum_q;
    flag_d       = flag_q;
    result_d     = result_q;
    edge_count_d = edge_count_q;
    cap_idx      = idx_q[RD_LATENCY-1];

    // Tag each issued read with its sample index so it is routed when the data returns.
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    vld_d[0] = (state_q == StIssue);
    idx_d[0] = cnt_q;

    if (vld_q[RD_LATENCY-1]) begin
      if (cap_idx == CNT_W'(0)) begin
        cen_d = pix;
      end else if (cap_idx == CNT_W'(1)) begin
        rgt_d = pix;
      end else if (cap_idx == CNT_W'(2)) begin
        blw_d = pix;
      end else begin
        for (int c = 0; c < 3; c++) sum_d[c] = sum_q[c] + SUM_W'(pix[c]);
      end
    end

    case (state_q)
      StIdle: begin
        if (enable_edge_detection) begin
          state_d      = StIssue;
          x_d          = XW'(M);
          y_d          = YW'(M);
          cnt_d        = '0;
          edge_count_d = '0;
        end
      end
      StIssue: begin
        if (cnt_q == CNT_W'(ISSUE_LAST)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          state_d = StDecide;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDecide: begin
        state_d = StWrite;
        flag_d  = |hit;
`ifdef EDGE_DETECTION_AVG_DEBUG_EN
        result_d = {avg[2], 8'h00, avg[1], avg[0]};
`else
        result_d = {31'b0, |hit};
`endif
      end
      StWrite: begin
        edge_count_d = edge_count_q + ADDR_W'(flag_q);
        sum_d        = '0;
        cnt_d        = '0;
        state_d      = StIssue;
        if (x_q == XW'(X_LAST)) begin
          x_d = XW'(M);
          if (y_q == YW'(Y_LAST)) begin
            state_d = StDone;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase

    // Dropping enable abandons the frame; edge_count is deliberately kept.
    if (!enable_edge_detection) begin
      state_d = StIdle;
      cnt_d   = '0;
      vld_d   = '0;
      sum_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      vld_q        <= '0;
      idx_q        <= '0;
      cen_q        <= '0;
      rgt_q        <= '0;
      blw_q        <= '0;
      sum_q        <= '0;
      flag_q       <= 1'b0;
      result_q     <= '0;
      edge_count_q <= '0;
    end else if (!pause) begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      vld_q        <= vld_d;
      idx_q        <= idx_d;
      cen_q        <= cen_d;
      rgt_q        <= rgt_d;
      blw_q        <= blw_d;
      sum_q        <= sum_d;
      flag_q       <= flag_d;
      result_q     <= result_d;
      edge_count_q <= edge_count_d;
    end
  end

  // Issue order: centre, right, below, then the sub-sampled window row-major.
  always_comb begin
    k  = 0;
    sx = 32'(x_q);
    sy = 32'(y_q);
    if (cnt_q == CNT_W'(1)) begin
      sx = 32'(x_q) + 1;
    end else if (cnt_q == CNT_W'(2)) begin
      sy = 32'(y_q) + 1;
    end else if (cnt_q != CNT_W'(0)) begin
      k  = 32'(cnt_q) - 3;
      sx = 32'(x_q) + (k % WS) * STEP - (M - 1);
      sy = 32'(y_q) + (k / WS) * STEP - (M - 1);
    end
  end

  always_comb begin
    sram.address        = '0;
    sram.wren           = 1'b0;
    sram.data_write     = '0;
    edge_detection_done = 1'b0;
    edge_count          = edge_count_q;
    case (state_q)
      StIssue: sram.address = ADDR_W'(SRC_BASE + sy * IMG_WIDTH + sx);
      StWrite: begin
        sram.address    = ADDR_W'(DST_BASE + 32'(y_q) * IMG_WIDTH + 32'(x_q));
        sram.wren       = 1'b1;
        sram.data_write = result_q;
      end
      StDone:  edge_detection_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_edge_detector_param.sv
// Self-checking bench for edge_detector_param on a small frame with a behavioural frame model.
module tb_edge_detector_param;
  localparam int unsigned IW    = 20;
  localparam int unsigned IH    = 12;
  localparam int unsigned AW    = 10;
  localparam int unsigned WIN   = 8;
  localparam int unsigned STP   = 2;
  localparam int unsigned RL    = 2;
  localparam int unsigned SRC   = 512;
  localparam int unsigned DST   = 0;
  localparam int unsigned M     = WIN / 2;
  localparam int unsigned WS    = WIN / STP;
  localparam int unsigned N     = WS * WS;
  localparam int unsigned COST  = N + RL + 5;
  localparam int unsigned PIX   = (IW - 2 * M) * (IH - 2 * M);
  localparam int unsigned FRAME = IW * IH;
  localparam logic [31:0] SENT  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pause = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    thr_r = 8'd0, thr_g = 8'd0, thr_b = 8'd0;
  logic          done;
  logic [AW-1:0] ecount;

  logic [31:0] src_img  [FRAME];
  logic [31:0] exp_dst  [FRAME];
  logic        exp_flag [FRAME];
  logic [31:0] dst_mem  [FRAME];
  logic [31:0] dpipe    [RL];
  logic        dst_clr = 1'b0;
  int          nwr = 0, stray = 0;
  int          n_vec = 0, n_bad = 0;

  edge_detector_param_if #(.ADDR_W(AW)) sram_if ();

  edge_detector_param #(
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH),
    .ADDR_W    (AW),
    .WINDOW    (WIN),
    .STEP      (STP),
    .RD_LATENCY(RL),
    .SRC_BASE  (SRC),
    .DST_BASE  (DST)
  ) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .pause                         (pause),
    .enable_edge_detection         (enable),
    .edge_detection_threshold_red  (thr_r),
    .edge_detection_threshold_green(thr_g),
    .edge_detection_threshold_blue (thr_b),
    .sram                          (sram_if.master),
    .edge_detection_done           (done),
    .edge_count                    (ecount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_word(input logic [AW-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    if (ai >= SRC && ai < SRC + FRAME) return src_img[ai-SRC];
    return 32'h0;
  endfunction

  // SRAM read path: RL-cycle latency, frozen by the arbiter while paused.
  always @(posedge clk) begin
    if (!pause) begin
      dpipe[0] <= src_word(sram_if.address);
      for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign sram_if.data_read = dpipe[RL-1];

  always @(posedge clk) begin
    if (dst_clr) begin
      for (int i = 0; i < FRAME; i++) dst_mem[i] <= SENT;
      nwr   <= 0;
      stray <= 0;
    end else if (sram_if.wren && !pause && rst_n) begin
      nwr <= nwr + 1;
      if (32'(sram_if.address) >= DST && 32'(sram_if.address) < DST + FRAME)
        dst_mem[32'(sram_if.address)-DST] <= sram_if.data_write;
      else
        stray <= stray + 1;
    end
  end

  function automatic int px(input int x, input int y, input int c);
    logic [31:0] w;
    w = src_img[y*IW+x];
    if (c == 0) return {24'h0, w[7:0]};
    if (c == 1) return {24'h0, w[15:8]};
    return {24'h0, w[31:24]};
  endfunction

  task automatic build_model(output int cnt);
    int sum, avg, avt, ce, r, b;
    int thr [3];
    logic [2:0] e;
    logic [7:0] av [3];
    thr[0] = {24'h0, thr_r};
    thr[1] = {24'h0, thr_g};
    thr[2] = {24'h0, thr_b};
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      exp_dst[i]  = SENT;
      exp_flag[i] = 1'b0;
    end
    for (int y = M; y < IH - M; y++) begin
      for (int x = M; x < IW - M; x++) begin
        for (int c = 0; c < 3; c++) begin
          sum = 0;
          for (int j = 0; j < WS; j++)
            for (int i = 0; i < WS; i++)
              sum += px(x - (M - 1) + i * STP, y - (M - 1) + j * STP, c);
          avg = sum / N;
          avt = avg + thr[c];
          ce  = px(x, y, c);
          r   = px(x + 1, y, c);
          b   = px(x, y + 1, c);
          e[c]  = ((ce > avt) && (r < avt || b < avt)) || ((ce <= avt) && (r > avt || b > avt));
          av[c] = avg[7:0];
        end
        exp_flag[y*IW+x] = |e;
        if (|e) cnt++;
`ifdef EDGE_DETECTION_AVG_DEBUG_EN
        exp_dst[y*IW+x] = {av[2], 8'h00, av[1], av[0]};
`else
        exp_dst[y*IW+x] = (|e) ? 32'h1 : 32'h0;
`endif
      end
    end
  endtask

  // kind: 0 uniform 8'h40, 1 red step at mid-width, 2 random
  task automatic load_frame(input int kind);
    for (int i = 0; i < FRAME; i++) begin
      if (kind == 0)      src_img[i] = 32'h4040_4040;
      else if (kind == 1) src_img[i] = ((i % IW) < IW / 2) ? 32'h0 : 32'd200;
      else                src_img[i] = $urandom;
    end
  endtask

  task automatic clear_dst();
    dst_clr = 1'b1;
    @(posedge clk); #1;
    dst_clr = 1'b0;
  endtask

  task automatic run_frame(input int pause_at, input string tag);
    int exp_cnt, cycles, exp_cyc;
    logic frozen;
    logic [AW-1:0] s_addr, s_cnt;
    logic s_wren, s_done;
    logic [31:0] s_dw;
    build_model(exp_cnt);
    clear_dst();
    exp_cyc = PIX * COST + 1 + ((pause_at > 0) ? 50 : 0);
    enable = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    n_vec++;
    if (ecount !== '0) begin
      n_bad++; $display("FAIL %s start_count: got %0d expected 0", tag, ecount);
    end
    n_vec++;
    if (32'(sram_if.address) !== SRC + M * IW + M) begin
      n_bad++;
      $display("FAIL %s start_addr: got %0d expected %0d", tag, sram_if.address, SRC + M * IW + M);
    end
    while (!done && cycles < exp_cyc + 200) begin
      if (cycles == pause_at) begin
        s_addr = sram_if.address; s_wren = sram_if.wren; s_dw = sram_if.data_write;
        s_done = done; s_cnt = ecount;
        frozen = 1'b1;
        pause  = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #1;
          cycles++;
          if (sram_if.address !== s_addr || sram_if.wren !== s_wren ||
              sram_if.data_write !== s_dw || done !== s_done || ecount !== s_cnt) frozen = 1'b0;
        end
        pause = 1'b0;
        n_vec++;
        if (frozen !== 1'b1) begin
          n_bad++; $display("FAIL %s pause_freeze: got changing outputs expected frozen", tag);
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    n_vec++;
    if (done !== 1'b1 || cycles != exp_cyc) begin
      n_bad++;
      $display("FAIL %s frame_cycles: got %0d (done=%b) expected %0d", tag, cycles, done, exp_cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL %s done_hold: got %b expected 1", tag, done);
    end
    for (int i = 0; i < FRAME; i++) begin
      n_vec++;
      if (dst_mem[i] !== exp_dst[i]) begin
        n_bad++;
        $display("FAIL %s dst[%0d]: got %h expected %h", tag, i, dst_mem[i], exp_dst[i]);
      end
    end
    n_vec++;
    if (32'(ecount) !== exp_cnt) begin
      n_bad++; $display("FAIL %s edge_count: got %0d expected %0d", tag, ecount, exp_cnt);
    end
    n_vec++;
    if (nwr != PIX || stray != 0) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d (stray %0d) expected %0d", tag, nwr, stray, PIX);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || sram_if.wren !== 1'b0 || sram_if.address !== '0 ||
        sram_if.data_write !== '0) begin
      n_bad++;
      $display("FAIL %s idle_after_disable: got done=%b wren=%b addr=%0d dw=%h expected 0",
               tag, done, sram_if.wren, sram_if.address, sram_if.data_write);
    end
    n_vec++;
    if (32'(ecount) !== exp_cnt) begin
      n_bad++; $display("FAIL %s count_hold: got %0d expected %0d", tag, ecount, exp_cnt);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (sram_if.wren !== 1'b0 || sram_if.address !== '0 || sram_if.data_write !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got wren=%b addr=%0d dw=%h expected 0", sram_if.wren,
               sram_if.address, sram_if.data_write);
    end
    n_vec++;
    if (done !== 1'b0 || ecount !== '0) begin
      n_bad++; $display("FAIL reset_status: got done=%b count=%0d expected 0", done, ecount);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_uniform();
    load_frame(0);
    thr_r = 8'd0; thr_g = 8'd0; thr_b = 8'd0;
    run_frame(0, "uniform");
  endtask

  task automatic test_red_step();
    load_frame(1);
    thr_r = 8'd10; thr_g = 8'd10; thr_b = 8'd10;
    run_frame(0, "red_step");
    thr_r = 8'd255;
    run_frame(0, "red_step_thr255");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      load_frame(2);
      thr_r = 8'($urandom_range(0, 60));
      thr_g = 8'($urandom_range(0, 60));
      thr_b = 8'($urandom_range(0, 60));
      run_frame(0, "random");
    end
  endtask

  task automatic test_pause();
    load_frame(2);
    thr_r = 8'd20; thr_g = 8'd5; thr_b = 8'd40;
    run_frame(1 + 7 * COST + 5, "pause_issue");
    run_frame(1 + 4 * COST - 1, "pause_write");
  endtask

  task automatic test_issue_order_and_abort();
    int exp_cnt, c0;
    int unsigned ea, i;
    load_frame(2);
    thr_r = 8'd15; thr_g = 8'd15; thr_b = 8'd15;
    build_model(exp_cnt);
    clear_dst();
    c0 = M * IW + M;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int kk = 0; kk < N + 3; kk++) begin
      if (kk == 0)      ea = SRC + c0;
      else if (kk == 1) ea = SRC + c0 + 1;
      else if (kk == 2) ea = SRC + c0 + IW;
      else begin
        i  = kk - 3;
        ea = SRC + (M + (i / WS) * STP - (M - 1)) * IW + (M + (i % WS) * STP - (M - 1));
      end
      n_vec++;
      if (32'(sram_if.address) !== ea || sram_if.wren !== 1'b0) begin
        n_bad++;
        $display("FAIL issue_order[%0d]: got addr=%0d wren=%b expected addr=%0d wren=0", kk,
                 sram_if.address, sram_if.wren, ea);
      end
      @(posedge clk); #1;
    end
    for (int kk = 0; kk < RL + 1; kk++) begin
      n_vec++;
      if (sram_if.wren !== 1'b0) begin
        n_bad++; $display("FAIL drain_wren[%0d]: got %b expected 0", kk, sram_if.wren);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (sram_if.wren !== 1'b1 || 32'(sram_if.address) !== DST + c0 ||
        sram_if.data_write !== exp_dst[c0]) begin
      n_bad++;
      $display("FAIL first_write: got wren=%b addr=%0d dw=%h expected wren=1 addr=%0d dw=%h",
               sram_if.wren, sram_if.address, sram_if.data_write, DST + c0, exp_dst[c0]);
    end
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (sram_if.wren !== 1'b0 || sram_if.address !== '0 || sram_if.data_write !== '0 ||
        done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: got wren=%b addr=%0d dw=%h done=%b expected 0", sram_if.wren,
               sram_if.address, sram_if.data_write, done);
    end
    n_vec++;
    if (ecount !== AW'(exp_flag[c0])) begin
      n_bad++; $display("FAIL abort_count: got %0d expected %0d", ecount, exp_flag[c0]);
    end
    run_frame(0, "restart");
  endtask

  task automatic test_reset_mid_write();
    int cycles;
    load_frame(0);
    clear_dst();
    enable = 1'b1;
    cycles = 0;
    while (sram_if.wren !== 1'b1 && cycles < 3 * COST) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_vec++;
    if (sram_if.wren !== 1'b1) begin
      n_bad++; $display("FAIL write_seen: got wren=%b expected 1 within bound", sram_if.wren);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (sram_if.wren !== 1'b0 || sram_if.address !== '0 || sram_if.data_write !== '0 ||
        done !== 1'b0 || ecount !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_write: got wren=%b addr=%0d dw=%h done=%b count=%0d expected 0",
               sram_if.wren, sram_if.address, sram_if.data_write, done, ecount);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_red_step();
    test_random();
    test_pause();
    test_issue_order_and_abort();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
